// File: rtl/mapreduce_noc_pkg.sv
// Shared constants and types for the map-reduce NoC node blocks.
package mapreduce_noc_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int FLIT_W = DATA_W + DEST_W;

  // Node that hosts the reducer, encoded {x[1:0], y[1:0]}
  localparam logic [DEST_W-1:0] REDUCER_NODE = 4'b1101;

  // Router port indices; the arbiter feeds PORT_L
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mapreduce_inject_arbiter_if.sv
// Requester-side and router-side signals of the injection arbiter.
// The slave modport is the arbiter; master is whatever surrounds it.
interface mapreduce_inject_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = mapreduce_noc_pkg::DATA_W,
  parameter int DEST_W = mapreduce_noc_pkg::DEST_W,
  parameter int FLIT_W = mapreduce_noc_pkg::FLIT_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*DEST_W-1:0] req_dest;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [FLIT_W-1:0]      flit_out;
  logic                   flit_valid;
  logic                   flit_ready;
  logic [NREQ-1:0]        grant;
  logic                   timeout;
  logic [15:0]            drop_count;

  modport master (
    output req_valid, req_data, req_dest, req_last, flit_ready,
    input  req_ready, flit_out, flit_valid, grant, timeout, drop_count
  );

  modport slave (
    input  req_valid, req_data, req_dest, req_last, flit_ready,
    output req_ready, flit_out, flit_valid, grant, timeout, drop_count
  );

endinterface

// File: rtl/mapreduce_inject_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req starting at ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  // Walk offsets 0..NREQ-1 from ptr and latch the first requester found
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any         = 1'b1;
        idx         = IDX_W'(pos);
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mapreduce_inject_arbiter.sv
// Shares the router local injection port among NREQ requesters with
// round-robin, packet-locked arbitration and a one-flit output register.
module mapreduce_inject_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = mapreduce_noc_pkg::DATA_W,
  parameter int DEST_W     = mapreduce_noc_pkg::DEST_W,
  parameter int FLIT_W     = mapreduce_noc_pkg::FLIT_W,
  parameter int HOLD_LIMIT = 15
) (
  input logic clk,
  input logic rst,
  mapreduce_inject_arbiter_if.slave bus
);

  import mapreduce_noc_pkg::*;

  localparam int IDX_W  = $clog2(NREQ);
  localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  next_ptr;
  logic [NREQ-1:0]   grant_q;
  logic [FLIT_W-1:0] flit_q;
  logic              flit_valid_q;
  logic              timeout_q;
  logic [15:0]       drop_q;
  logic [HOLD_W-1:0] hold_cnt;

  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic              slot_free;
  logic              owner_valid;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic [DEST_W-1:0] owner_dest;
  logic              accept;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Owner's word is taken only when the output register is empty or draining now
  always_comb begin
    slot_free   = !flit_valid_q || bus.flit_ready;
    owner_valid = bus.req_valid[owner];
    owner_last  = bus.req_last[owner];
    owner_data  = bus.req_data[int'(owner)*DATA_W +: DATA_W];
    owner_dest  = bus.req_dest[int'(owner)*DEST_W +: DEST_W];
    accept      = (state == LOCKED) && owner_valid && slot_free;
    next_ptr    = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  end

  assign bus.req_ready  = accept ? grant_q : '0;
  assign bus.grant      = grant_q;
  assign bus.flit_out   = flit_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.drop_count = drop_q;

  // Arbitration FSM, output register, drop counter and idle-hold timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      grant_q      <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      drop_q       <= '0;
      hold_cnt     <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (flit_valid_q && bus.flit_ready) begin
        flit_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            grant_q  <= pick_onehot;
            hold_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            hold_cnt <= '0;
            if (owner_data != '0) begin
              flit_q       <= {owner_data, owner_dest};
              flit_valid_q <= 1'b1;
            end else if (drop_q != 16'hFFFF) begin
              drop_q <= drop_q + 16'd1;
            end
            if (owner_last) begin
              state   <= IDLE;
              rr_ptr  <= next_ptr;
              grant_q <= '0;
            end
          end else if (!owner_valid) begin
            // HOLD_LIMIT idle cycles are tolerated; the next idle one releases
            if (hold_cnt == HOLD_W'(HOLD_LIMIT)) begin
              state     <= IDLE;
              rr_ptr    <= next_ptr;
              grant_q   <= '0;
              timeout_q <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapreduce_inject_arbiter.sv
// Directed self-checking bench for mapreduce_inject_arbiter.
module tb_mapreduce_inject_arbiter;

  localparam int NREQ       = 4;
  localparam int DATA_W     = 32;
  localparam int DEST_W     = 4;
  localparam int FLIT_W     = 36;
  localparam int HOLD_LIMIT = 15;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mapreduce_inject_arbiter_if #(
    .NREQ(NREQ), .DATA_W(DATA_W), .DEST_W(DEST_W), .FLIT_W(FLIT_W)
  ) bus ();

  mapreduce_inject_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .DEST_W(DEST_W), .FLIT_W(FLIT_W),
    .HOLD_LIMIT(HOLD_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] d,
                         input logic [3:0] dst, input logic l);
    bus.req_valid[i]           = v;
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req_dest[i*DEST_W +: DEST_W] = dst;
    bus.req_last[i]            = l;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_dest  = '0;
    bus.req_last  = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    bus.flit_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_grant: grant=%b req_ready=%b expected 0000/0000", bus.grant, bus.req_ready);
    end
    n_checks++;
    if (bus.flit_valid !== 1'b0 || bus.flit_out !== 36'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_flit: valid=%b out=%h expected 0/0", bus.flit_valid, bus.flit_out);
    end
    n_checks++;
    if (bus.timeout !== 1'b0 || bus.drop_count !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_misc: timeout=%b drop=%0d expected 0/0", bus.timeout, bus.drop_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    step();
    set_req(0, 1'b1, 32'hA5A5_0001, 4'b1101, 1'b1);
    bus.flit_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_idle: grant=%b req_ready=%b expected 0000/0000", bus.grant, bus.req_ready);
    end
    step();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL single_grant: grant=%b req_ready=%b expected 0001/0001", bus.grant, bus.req_ready);
    end
    step();
    set_req(0, 1'b0, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (bus.flit_valid !== 1'b1 || bus.flit_out !== 36'hA5A5_0001_D || bus.grant !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_flit: valid=%b out=%h grant=%b expected 1/a5a50001d/0000",
               bus.flit_valid, bus.flit_out, bus.grant);
    end
    step();
    n_checks++;
    if (bus.flit_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_drain: valid=%b expected 0", bus.flit_valid);
    end
  endtask

  // Fresh reset so the pointer starts at requester 0: order 0,1,2,3,0
  task automatic test_round_robin();
    logic [35:0] exp_flit;
    int r;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, 32'h0000_0100 + 32'(i), 4'(i), 1'b1);
    end
    bus.flit_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      r = k % NREQ;
      exp_flit = {32'h0000_0100 + 32'(r), 4'(r)};
      step();
      n_checks++;
      if (bus.grant !== 4'(1 << r) || bus.req_ready !== 4'(1 << r)) begin
        n_fail++;
        $display("[TB] FAIL rr_grant[%0d]: grant=%b req_ready=%b expected owner %0d", k, bus.grant, bus.req_ready, r);
      end
      step();
      n_checks++;
      if (bus.flit_valid !== 1'b1 || bus.flit_out !== exp_flit || bus.grant !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL rr_flit[%0d]: valid=%b out=%h grant=%b expected 1/%h/0000",
                 k, bus.flit_valid, bus.flit_out, bus.grant, exp_flit);
      end
    end
    clear_reqs();
    step();
  endtask

  // Pointer is at 1: req1 locks, req2 waits through the whole packet
  task automatic test_lock_backpressure();
    set_req(1, 1'b1, 32'h1111_0001, 4'b1101, 1'b0);
    set_req(2, 1'b1, 32'h2222_0001, 4'b0010, 1'b1);
    bus.flit_ready = 1'b1;
    step();
    n_checks++;
    if (bus.grant !== 4'b0010 || bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL lock_grant: grant=%b req_ready=%b expected 0010/0010", bus.grant, bus.req_ready);
    end
    step();
    set_req(1, 1'b1, 32'h1111_0002, 4'b1101, 1'b0);
    bus.flit_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.flit_valid !== 1'b1 || bus.flit_out !== 36'h1111_0001_D || bus.grant !== 4'b0010 ||
          bus.req_ready !== 4'b0000 || bus.timeout !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL lock_hold[%0d]: valid=%b out=%h grant=%b req_ready=%b timeout=%b expected 1/11110001d/0010/0000/0",
                 c, bus.flit_valid, bus.flit_out, bus.grant, bus.req_ready, bus.timeout);
      end
      step();
    end
    bus.flit_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL lock_reload: req_ready=%b expected 0010", bus.req_ready);
    end
    step();
    set_req(1, 1'b1, 32'h1111_0003, 4'b1101, 1'b1);
    n_checks++;
    if (bus.flit_valid !== 1'b1 || bus.flit_out !== 36'h1111_0002_D || bus.grant !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL lock_word2: valid=%b out=%h grant=%b expected 1/11110002d/0010",
               bus.flit_valid, bus.flit_out, bus.grant);
    end
    step();
    set_req(1, 1'b0, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (bus.flit_out !== 36'h1111_0003_D || bus.grant !== 4'b0000 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lock_word3: out=%h grant=%b timeout=%b expected 11110003d/0000/0",
               bus.flit_out, bus.grant, bus.timeout);
    end
    step();
    n_checks++;
    if (bus.grant !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL lock_next: grant=%b expected 0100", bus.grant);
    end
    step();
    set_req(2, 1'b0, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (bus.flit_out !== 36'h2222_0001_2) begin
      n_fail++;
      $display("[TB] FAIL lock_req2: out=%h expected 222200012", bus.flit_out);
    end
    step();
  endtask

  task automatic test_zero_drop();
    set_req(3, 1'b1, 32'h0, 4'b0110, 1'b0);
    bus.flit_ready = 1'b1;
    step();
    n_checks++;
    if (bus.grant !== 4'b1000 || bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL drop_grant: grant=%b req_ready=%b expected 1000/1000", bus.grant, bus.req_ready);
    end
    step();
    n_checks++;
    if (bus.flit_valid !== 1'b0 || bus.drop_count !== 16'd1 || bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL drop_first: valid=%b drop=%0d req_ready=%b expected 0/1/1000",
               bus.flit_valid, bus.drop_count, bus.req_ready);
    end
    step();
    set_req(3, 1'b1, 32'h0000_1234, 4'b0110, 1'b1);
    n_checks++;
    if (bus.flit_valid !== 1'b0 || bus.drop_count !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL drop_second: valid=%b drop=%0d expected 0/2", bus.flit_valid, bus.drop_count);
    end
    step();
    set_req(3, 1'b0, 32'h0, 4'h0, 1'b0);
    n_checks++;
    if (bus.flit_valid !== 1'b1 || bus.flit_out !== 36'h0000_1234_6 || bus.drop_count !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL drop_flit: valid=%b out=%h drop=%0d expected 1/000012346/2",
               bus.flit_valid, bus.flit_out, bus.drop_count);
    end
    step();
  endtask

  // HOLD_LIMIT idle cycles are allowed, the one after releases: pulse on edge 16
  task automatic test_timeout();
    int waited;
    set_req(0, 1'b1, 32'hCAFE_0001, 4'b0001, 1'b0);
    bus.flit_ready = 1'b1;
    step();
    step();
    set_req(0, 1'b0, 32'h0, 4'h0, 1'b0);
    waited = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.timeout === 1'b1) begin
        waited = n;
        break;
      end
    end
    n_checks++;
    if (waited != HOLD_LIMIT + 1) begin
      n_fail++;
      $display("[TB] FAIL timeout_delay: pulse after %0d cycles (0 = none) expected %0d", waited, HOLD_LIMIT + 1);
    end
    n_checks++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL timeout_grant: grant=%b expected 0000", bus.grant);
    end
    set_req(0, 1'b1, 32'h0000_00A0, 4'b0000, 1'b1);
    set_req(1, 1'b1, 32'h0000_00A1, 4'b0001, 1'b1);
    step();
    n_checks++;
    if (bus.timeout !== 1'b0 || bus.grant !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL timeout_rr: timeout=%b grant=%b expected 0/0010", bus.timeout, bus.grant);
    end
    step();
    set_req(1, 1'b0, 32'h0, 4'h0, 1'b0);
    step();
    n_checks++;
    if (bus.grant !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL timeout_next: grant=%b expected 0001", bus.grant);
    end
    step();
    set_req(0, 1'b0, 32'h0, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_async_reset();
    set_req(1, 1'b1, 32'hBEEF_0001, 4'b1101, 1'b0);
    bus.flit_ready = 1'b1;
    step();
    step();
    set_req(1, 1'b1, 32'hBEEF_0002, 4'b1101, 1'b1);
    bus.flit_ready = 1'b0;
    n_checks++;
    if (bus.flit_valid !== 1'b1 || bus.grant !== 4'b0010 || bus.drop_count !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: valid=%b grant=%b drop=%0d expected 1/0010/2",
               bus.flit_valid, bus.grant, bus.drop_count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.flit_valid !== 1'b0 || bus.grant !== 4'b0000 || bus.drop_count !== 16'd0 || bus.flit_out !== 36'h0) begin
      n_fail++;
      $display("[TB] FAIL areset_now: valid=%b grant=%b drop=%0d out=%h expected 0/0000/0/0",
               bus.flit_valid, bus.grant, bus.drop_count, bus.flit_out);
    end
    clear_reqs();
    bus.flit_ready = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h0000_0B00, 4'b0000, 1'b1);
    set_req(1, 1'b1, 32'h0000_0B01, 4'b0001, 1'b1);
    step();
    n_checks++;
    if (bus.grant !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL areset_restart: grant=%b expected 0001", bus.grant);
    end
    clear_reqs();
    step();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.flit_ready = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_dest   = '0;
    bus.req_last   = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock_backpressure();
    test_zero_drop();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mapreduce_inject_arbiter.md
Name: mapreduce_inject_arbiter

Overview:
- Shares one router local injection port between NREQ mapper-side requesters. Round-robin arbitration with packet lock.
- Each accepted 32-bit word is tagged with its destination node field to form a 36-bit flit. The flit is held in an output register until the router local port accepts it.
- Zero-valued words are consumed and dropped. They never reach the NoC.
- Sits between the mapper cores of a node and the local (index 4) input of that node's router.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 32, payload width.
- DEST_W, 4, destination field width {x[1:0],y[1:0]}.
- FLIT_W, 36, must equal DATA_W+DEST_W.
- HOLD_LIMIT, 15, idle cycles allowed inside a locked packet before forced release.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- req_valid  in  NREQ  requester i has a word.
- req_data  in  NREQ*DATA_W  payload; slice i is [i*DATA_W +: DATA_W].
- req_dest  in  NREQ*DEST_W  destination node; slice i.
- req_last  in  NREQ  word is the final word of its packet.
- req_ready  out  NREQ  word of requester i is accepted this cycle.
- flit_out  out  FLIT_W  {data, dest}, dest in bits [DEST_W-1:0].
- flit_valid  out  1  flit_out holds a flit.
- flit_ready  in  1  router accepts flit_out this cycle.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- timeout  out  1  one-cycle pulse on forced release.
- drop_count  out  16  saturating count of dropped zero words.

Behaviour:
- Reset (async, rst=1): state IDLE, grant=0, rr_ptr=0, flit_valid=0, flit_out=0, timeout=0, drop_count=0, hold_cnt=0.
  - Reset mid-packet or with a flit pending discards everything; no partial recovery.
- slot_free = !flit_valid || flit_ready.
- Output transfer happens when flit_valid && flit_ready; flit_valid clears unless reloaded in the same cycle.
- FSM IDLE:
  - If any req_valid, pick the first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Register owner=i, grant=onehot(i), go LOCKED. No word is accepted in the IDLE cycle, so arbitration latency is 1 cycle.
- FSM LOCKED:
  - req_ready[owner] = req_valid[owner] && slot_free. It is combinational from flit_ready. All other req_ready are 0.
  - Accept with data!=0: flit_out <= {req_data[owner], req_dest[owner]}, flit_valid <= 1. The flit is visible the cycle after acceptance.
  - Accept with data==0: word consumed, output register untouched, drop_count += 1, saturating at 16'hFFFF.
  - Accept with req_last=1: go IDLE, rr_ptr <= owner+1 mod NREQ, grant <= 0.
  - hold_cnt resets to 0 on every accept. It increments on each cycle where req_valid[owner]=0.
  - When hold_cnt reaches HOLD_LIMIT and valid is still low: go IDLE, rr_ptr advances, timeout pulses for 1 cycle, hold_cnt <= 0.
  - Backpressure (valid high, slot not free) does not count toward hold_cnt.
- Simultaneous events:
  - A new accept and an output drain in the same cycle reloads the register; flit_valid stays 1.
  - A single word with last=1 in the first LOCKED cycle completes the packet.
- Throughput: 1 word/cycle in a locked packet while flit_ready=1. Each packet costs 1 extra IDLE cycle.
- flit_out is stable while flit_valid=1 and flit_ready=0.
- Lock is never broken by other requesters; fairness is per packet.

Decomposition:
- Shared package mapreduce_noc_pkg holds:
  - Constants DATA_W=32, DEST_W=4, FLIT_W=36.
  - Reducer node constant REDUCER_NODE=4'b1101.
  - Port index constants (N=0, E=1, S=2, W=3, L=4).
  - FSM state enum {IDLE, LOCKED}.
- One sub-module: rr_pick. Combinational rotating priority encoder with inputs req[NREQ], ptr; outputs onehot, idx, any.

Test Plan:
- Single packet: req0 sends 0xA5A5_0001 (dest 4'b1101), last=1, flit_ready=1 -> grant=0001 at cycle 1, req_ready[0] at cycle 1, flit_out=36'hA5A5_0001_D with flit_valid at cycle 2.
- Round robin: req0..3 all valid, single-word packets -> grant order 0,1,2,3,0. One flit every 2 cycles.
- Packet lock with backpressure:
  - Setup: req1 sends a 3-word packet, req2 valid throughout, flit_ready low for 4 cycles mid-packet.
  - Response: flit_out held stable, no req2 grant until req1 last is accepted, words in order, no timeout.
- Zero drop: req3 sends 0x0, 0x0, 0x1234 (last) -> 2 req_ready pulses produce no flit; drop_count=2; one flit 0x1234.
- Timeout: req0 sends 1 word, last=0, then valid low -> after 15 idle cycles timeout pulses, grant=0, and the next arbitration starts at rr_ptr=1.
- Async reset: assert rst while flit_valid=1 mid-packet -> flit_valid, grant and drop_count go 0 immediately without a clock edge. After release, arbitration restarts from req0.
